// File: rtl/imem_boot_loader.sv
// Boot loader for the core's instruction memory. Holds the core in reset,
// receives a length-prefixed little-endian byte stream over valid/ready,
// writes the assembled words sequentially, then releases the core. Also
// muxes the instruction-memory address between loader and core fetch.
module imem_boot_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       imem_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_FLUSH,
    S_RUN
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t      state;
  logic [15:0] len;        // word count from the stream header
  logic [1:0]  b;          // byte position within the current word
  logic [15:0] w;          // index of the word being assembled/written
  logic [23:0] word_buf;   // low three bytes of the word in progress
  logic        wr_pend;    // a word completed last cycle (written or not)
  logic        hs;
  logic [15:0] len_in;

  // Byte transfer: rx_ready is a pure state decode.
  // NOTE: rx_ready must not look at rx_valid, or a sender that waits for
  // ready before raising valid would deadlock against this block.
  always_comb begin
    rx_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  end

  assign hs     = rx_valid && rx_ready;
  assign len_in = {rx_data, len[7:0]};

  // Loader owns the address while busy so a pending write sees its own address.
  always_comb begin
    imem_addr = fetch_addr;
    if (busy) imem_addr = {{(30-ADDR_W){1'b0}}, w[ADDR_W-1:0], 2'b00};
  end

  // Load sequencer with registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; reset here is synchronous and only touches
  // control and datapath registers, never the instruction memory itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      len          <= '0;
      b            <= '0;
      w            <= '0;
      word_buf     <= '0;
      wr_pend      <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      core_rst_n   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      done    <= 1'b0;
      mem_we  <= 1'b0;
      wr_pend <= 1'b0;

      // The write cycle advances the word index; only real writes are counted.
      if (wr_pend) begin
        w <= w + 16'd1;
        if (mem_we) words_loaded <= words_loaded + 16'd1;
      end

      unique case (state)
        S_IDLE, S_RUN: begin
          if (start) begin
            state        <= S_LEN_LO;
            busy         <= 1'b1;
            core_rst_n   <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            b            <= '0;
            w            <= '0;
          end
        end
        S_LEN_LO: begin
          if (hs) begin
            len[7:0] <= rx_data;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (hs) begin
            len[15:8] <= rx_data;
            err       <= (len_in > DEPTH16);
            if (len_in != 16'd0) begin
              state <= S_DATA;
            end else begin
              state      <= S_RUN;
              busy       <= 1'b0;
              core_rst_n <= 1'b1;
              done       <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (hs) begin
            b <= b + 2'd1;
            unique case (b)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              2'd3: begin
                mem_wdata <= {rx_data, word_buf};
                mem_waddr <= w[ADDR_W-1:0];
                mem_we    <= (w < DEPTH16);
                wr_pend   <= 1'b1;
                if (w == len - 16'd1) state <= S_FLUSH;
              end
              default: ;
            endcase
          end
        end
        S_FLUSH: begin
          state      <= S_RUN;
          busy       <= 1'b0;
          core_rst_n <= 1'b1;
          done       <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          core_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed sequences for the multi-cycle corner
// cases plus a table of randomized loads checked against a simple model of
// the expected memory image.
module tb_imem_boot_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [31:0]       fetch_addr;
  logic [31:0]       imem_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       words_loaded;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .fetch_addr   (fetch_addr),
    .imem_addr    (imem_addr),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit stuck = 1'b0;

  // Observed writes and done pulses.
  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  int                wq_cyc[$];
  int                done_cnt = 0;
  int                done_cyc = 0;

  typedef struct {
    int len;
    int pct;         // probability (%) that rx_valid is offered on a cycle
    bit poke;        // pulse start mid-stream; must be ignored
    bit exp_err;
    int exp_loaded;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sample outputs mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(mem_waddr);
      wq_data.push_back(mem_wdata);
      wq_cyc.push_back(cyc);
      check("imem_addr_during_write", imem_addr, 32'(mem_waddr) << 2);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte, optionally after random idle cycles, and wait for its handshake.
  task automatic send_byte(input logic [7:0] bt, input int pct);
    int guard = 0;
    if (stuck) return;
    while (pct < 100 && int'($urandom_range(99)) >= pct) begin
      rx_valid = 1'b0;
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = bt;
    while (!rx_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      stuck = 1'b1;
      $display("FAIL byte_accept: rx_ready still 0 after 20 cycles, required 1");
      rx_valid = 1'b0;
    end else begin
      tick();
    end
  endtask

  task automatic send_words(input logic [31:0] words[$], input int pct);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) send_byte(words[i][8*k +: 8], pct);
    end
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) @(negedge clk);
    check("done_seen", done_cnt, 1);
    tick();
    tick();
    check("done_single_pulse", done_cnt, 1);
  endtask

  // Model: a length-len load writes word i at address i for every i below DEPTH.
  task automatic compare_image(input string name, input logic [31:0] words[$], input int len);
    int n_exp = (len < DEPTH) ? len : DEPTH;
    int first_bad = -1;
    check({name, "_write_count"}, wq_addr.size(), n_exp);
    if (wq_addr.size() == n_exp) begin
      for (int i = 0; i < n_exp; i++) begin
        if (first_bad < 0 && (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== words[i]))
          first_bad = i;
      end
      check({name, "_image_first_bad_index"}, first_bad, -1);
    end
  endtask

  initial begin
    logic [31:0] words[$];
    logic [7:0]  seq[$];

    rst_n      = 1'b0;
    start      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    fetch_addr = 32'h0000_0100;

    // Reset state.
    repeat (3) tick();
    check("rst_rx_ready", rx_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_waddr", mem_waddr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_imem_addr", imem_addr, 32'h0000_0100);
    rst_n = 1'b1;
    tick();

    // Two-word load at full rate.
    clear_mon();
    pulse_start();
    check("t1_busy_after_start", busy, 1);
    check("t1_core_held", core_rst_n, 0);
    seq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h60, 8'h00};
    foreach (seq[i]) send_byte(seq[i], 100);
    rx_valid = 1'b0;
    wait_done(20);
    check("t1_write_count", wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      check("t1_w0_addr", wq_addr[0], 0);
      check("t1_w0_data", wq_data[0], 32'h0050_0093);
      check("t1_w1_addr", wq_addr[1], 1);
      check("t1_w1_data", wq_data[1], 32'h0060_0113);
      check("t1_write_spacing", wq_cyc[1] - wq_cyc[0], 4);
      check("t1_done_after_last_write", done_cyc - wq_cyc[1], 1);
    end
    check("t1_core_released", core_rst_n, 1);
    check("t1_words_loaded", words_loaded, 2);
    check("t1_err", err, 0);
    check("t1_busy", busy, 0);
    check("t1_rx_ready_run", rx_ready, 0);
    fetch_addr = $urandom();
    #1;
    check("t1_imem_follows_fetch", imem_addr, fetch_addr);

    // Zero-length load.
    clear_mon();
    pulse_start();
    send_byte(8'h00, 100);
    send_byte(8'h00, 100);
    rx_valid = 1'b0;
    check("t2_done_next_cycle", done, 1);
    check("t2_core_released", core_rst_n, 1);
    check("t2_err", err, 0);
    check("t2_busy", busy, 0);
    repeat (4) tick();
    check("t2_no_writes", wq_addr.size(), 0);
    check("t2_done_count", done_cnt, 1);
    check("t2_words_loaded", words_loaded, 0);

    // Overflow: len = 1025.
    clear_mon();
    pulse_start();
    send_byte(8'h01, 100);
    check("t3_err_before_len_hi", err, 0);
    send_byte(8'h04, 100);
    check("t3_err_after_len_hi", err, 1);
    words.delete();
    for (int i = 0; i < 1025; i++) words.push_back($urandom());
    send_words(words, 100);
    rx_valid = 1'b0;
    wait_done(50);
    compare_image("t3", words, 1025);
    check("t3_words_loaded", words_loaded, 16'd1024);
    check("t3_err_sticky", err, 1);
    check("t3_core_released", core_rst_n, 1);

    // Reload from RUN with err set.
    clear_mon();
    pulse_start();
    check("t4_core_dropped", core_rst_n, 0);
    check("t4_err_cleared", err, 0);
    check("t4_words_cleared", words_loaded, 0);
    check("t4_busy", busy, 1);
    seq = '{8'h01, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
    foreach (seq[i]) send_byte(seq[i], 100);
    rx_valid = 1'b0;
    wait_done(20);
    words = '{32'h0020_81B3};
    compare_image("t4", words, 1);
    check("t4_core_released", core_rst_n, 1);
    check("t4_words_loaded", words_loaded, 1);

    // Randomized loads with backpressure.
    vecs[0] = '{len: 3, pct: 50,  poke: 1'b0, exp_err: 1'b0, exp_loaded: 3};
    vecs[1] = '{len: 3, pct: 30,  poke: 1'b1, exp_err: 1'b0, exp_loaded: 3};
    vecs[2] = '{len: 1, pct: 40,  poke: 1'b0, exp_err: 1'b0, exp_loaded: 1};
    vecs[3] = '{len: 6, pct: 70,  poke: 1'b1, exp_err: 1'b0, exp_loaded: 6};
    vecs[4] = '{len: 0, pct: 40,  poke: 1'b0, exp_err: 1'b0, exp_loaded: 0};
    vecs[5] = '{len: 9, pct: 100, poke: 1'b1, exp_err: 1'b0, exp_loaded: 9};
    foreach (vecs[v]) begin
      string nm;
      logic [31:0] one[$];
      nm = $sformatf("rnd%0d", v);
      clear_mon();
      words.delete();
      for (int i = 0; i < vecs[v].len; i++) words.push_back($urandom());
      pulse_start();
      send_byte(8'(vecs[v].len), vecs[v].pct);
      send_byte(8'(vecs[v].len >> 8), vecs[v].pct);
      for (int i = 0; i < vecs[v].len; i++) begin
        if (vecs[v].poke && i == vecs[v].len / 2) begin
          rx_valid = 1'b0;
          pulse_start();
        end
        one = '{words[i]};
        send_words(one, vecs[v].pct);
      end
      rx_valid = 1'b0;
      wait_done(vecs[v].len * 40 + 40);
      compare_image(nm, words, vecs[v].len);
      check({nm, "_words_loaded"}, words_loaded, vecs[v].exp_loaded);
      check({nm, "_err"}, err, vecs[v].exp_err);
      check({nm, "_core_released"}, core_rst_n, 1);
    end

    // Reset one cycle after the 6th byte.
    clear_mon();
    pulse_start();
    seq = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (seq[i]) send_byte(seq[i], 100);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_mon();
    check("t6_rx_ready", rx_ready, 0);
    check("t6_mem_we", mem_we, 0);
    check("t6_mem_waddr", mem_waddr, 0);
    check("t6_mem_wdata", mem_wdata, 0);
    check("t6_core_rst_n", core_rst_n, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_err", err, 0);
    check("t6_words_loaded", words_loaded, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (8) tick();
    check("t6_idle_not_ready", rx_ready, 0);
    rx_valid = 1'b0;
    check("t6_no_writes_after_reset", wq_addr.size(), 0);
    pulse_start();
    seq = '{8'h01, 8'h00, 8'h34, 8'h12, 8'hFE, 8'hCA};
    foreach (seq[i]) send_byte(seq[i], 100);
    rx_valid = 1'b0;
    wait_done(20);
    words = '{32'hCAFE_1234};
    compare_image("t6", words, 1);
    check("t6_core_released", core_rst_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
